// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master-side bus bundle for the CPU-to-AXI bridge.
// The master modport is the bridge; the slave modport is the interconnect or memory.
interface cpu_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's instruction and data SRAM-like ports onto one AXI3 master
// with a single outstanding transaction. The data port wins when both request.
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  cpu_axi_bridge_if.master axi
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]  state, state_nxt;
  logic        own_data;          // 1: data port owns the transaction, 0: inst port
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        aw_done, w_done;   // AW / W handshakes already completed in WR_REQ
  logic        accept_data, accept_inst;
  logic        aw_hs, w_hs;
  logic [1:0]  size_n;            // size with the reserved code 3 folded onto word
  logic [3:0]  strb;

  // Requests are only looked at in IDLE; data has priority over inst.
  assign accept_data  = (state == S_IDLE) && data_req;
  assign accept_inst  = (state == S_IDLE) && !data_req && inst_req;
  assign data_addr_ok = accept_data;
  assign inst_addr_ok = accept_inst;

  assign data_data_ok = (state == S_DONE) &&  own_data;
  assign inst_data_ok = (state == S_DONE) && !own_data;

  assign aw_hs  = axi.awvalid && axi.awready;
  assign w_hs   = axi.wvalid  && axi.wready;
  assign size_n = (lat_size == 2'd3) ? 2'd2 : lat_size;

  // Byte-lane strobes for the latched size and address offset.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    strb = 4'b1111;
    case (size_n)
      2'd0:    strb = 4'b0001 << lat_addr[1:0];
      2'd1:    strb = lat_addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Next-state logic for the single-outstanding transaction sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_data)      state_nxt = data_wr ? S_WR_REQ : S_RD_ADDR;
        else if (accept_inst) state_nxt = inst_wr ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: if (axi.arready) state_nxt = S_RD_DATA;
      S_RD_DATA: if (axi.rvalid)  state_nxt = S_DONE;
      S_WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_RESP;
      S_WR_RESP: if (axi.bvalid)  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Latch the accepted request; these fields drive the AXI side until DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own_data  <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (accept_data) begin
      own_data  <= 1'b1;
      lat_size  <= data_size;
      lat_addr  <= data_addr;
      lat_wdata <= data_wdata;
    end else if (accept_inst) begin
      own_data  <= 1'b0;
      lat_size  <= inst_size;
      lat_addr  <= inst_addr;
      lat_wdata <= inst_wdata;
    end
  end

  // Track AW and W handshakes independently; cleared whenever not in WR_REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == S_WR_REQ) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  // Capture read data into the owner's register; it holds until that port reads again.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the data registers are reset too, since the CPU may sample rdata before its first read.
    if (!resetn) begin
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
    end else if ((state == S_RD_DATA) && axi.rvalid) begin
      if (own_data) data_rdata <= axi.rdata;
      else          inst_rdata <= axi.rdata;
    end
  end

  // AR channel: single-beat incrementing reads.
  assign axi.arid    = {3'b000, own_data};
  assign axi.araddr  = lat_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_n};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (state == S_RD_ADDR);
  assign axi.rready  = (state == S_RD_DATA);

  // AW / W / B channels: single-beat writes, AW and W dropped after their own handshake.
  assign axi.awid    = {3'b000, own_data};
  assign axi.awaddr  = lat_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, size_n};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (state == S_WR_REQ) && !aw_done;
  assign axi.wid     = {3'b000, own_data};
  assign axi.wdata   = lat_wdata;
  assign axi.wstrb   = strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state == S_WR_REQ) && !w_done;
  assign axi.bready  = (state == S_WR_RESP);

  // Response IDs and status are not used: the owner comes from the latch.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: a delay-configurable AXI slave,
// scoreboard queues filled at request time and drained as the DUT responds.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;

  cpu_axi_bridge_if axi();

  cpu_axi_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit wr; logic [3:0] id; logic [31:0] addr; logic [2:0] size; } aexp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [3:0] strb; } wexp_t;
  typedef struct { bit port; bit wr; logic [31:0] rdata; } cexp_t;

  aexp_t aq[$];
  wexp_t wq[$];
  cexp_t cq[$];
  logic [31:0] rq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd0) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (s == 2'd1) begin
      return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
    end
    return 4'b1111;
  endfunction

  // ---------------- AXI slave model ----------------
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  bit ar_v = 0, ar_hs = 0, r_hs = 0, aw_v = 0, aw_hs = 0, w_v = 0, w_hs = 0, b_hs = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  logic [31:0] r_cur = 32'h0;

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = 32'h0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        if (r_hs) r_pend = 0; else if (r_pend) r_cnt++;
        if (ar_hs) begin
          r_pend = 1; r_cnt = 0; ar_cnt = 0;
          r_cur = (rq.size() > 0) ? rq.pop_front() : 32'hDEAD_BEEF;
        end else if (ar_v) ar_cnt++;
        if (aw_hs) begin aw_got = 1; aw_cnt = 0; end else if (aw_v) aw_cnt++;
        if (w_hs)  begin w_got  = 1; w_cnt  = 0; end else if (w_v)  w_cnt++;
        if (b_hs) b_pend = 0; else if (b_pend) b_cnt++;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      end
      axi.arready = resetn && axi.arvalid && (ar_cnt >= ar_delay);
      axi.rvalid  = r_pend && (r_cnt >= r_delay);
      axi.rdata   = axi.rvalid ? r_cur : 32'h0;
      axi.rlast   = axi.rvalid;
      axi.awready = resetn && axi.awvalid && (aw_cnt >= aw_delay);
      axi.wready  = resetn && axi.wvalid && (w_cnt >= w_delay);
      axi.bvalid  = b_pend && (b_cnt >= b_delay);
    end
  end

  // ---------------- Monitor / scoreboard (mid-cycle sampling) ----------------
  int ar_first_cyc = 0, br_first_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ok_cyc = 0;
  int aw_hi_cnt = 0, w_hi_cnt = 0;
  bit ar_prev = 0, br_prev = 0;
  aexp_t m_a;
  wexp_t m_w;
  cexp_t m_c;

  always @(negedge clk) begin
    ar_v  = axi.arvalid; ar_hs = axi.arvalid && axi.arready;
    r_hs  = axi.rvalid && axi.rready;
    aw_v  = axi.awvalid; aw_hs = axi.awvalid && axi.awready;
    w_v   = axi.wvalid;  w_hs  = axi.wvalid && axi.wready;
    b_hs  = axi.bvalid && axi.bready;
    if (axi.awvalid) aw_hi_cnt++;
    if (axi.wvalid)  w_hi_cnt++;
    if (axi.arvalid && !ar_prev) ar_first_cyc = cyc;
    ar_prev = axi.arvalid;
    if (axi.bready && !br_prev) br_first_cyc = cyc;
    br_prev = axi.bready;
    if (aw_hs) aw_hs_cyc = cyc;
    if (w_hs)  w_hs_cyc  = cyc;
    if (b_hs)  b_hs_cyc  = cyc;

    if (ar_hs) begin
      if (aq.size() == 0) check("ar_unexpected", 32'(axi.arvalid), 32'd0);
      else begin
        m_a = aq.pop_front();
        check("ar_is_read", 32'(m_a.wr), 32'd0);
        check("arid",   32'(axi.arid),   32'(m_a.id));
        check("araddr", axi.araddr,      m_a.addr);
        check("arsize", 32'(axi.arsize), 32'(m_a.size));
        check("arlen_burst", {22'd0, axi.arlen, axi.arburst}, 32'h1);
        check("ar_lock_cache_prot", 32'({axi.arlock, axi.arcache, axi.arprot}), 32'd0);
      end
    end
    if (aw_hs) begin
      if (aq.size() == 0) check("aw_unexpected", 32'(axi.awvalid), 32'd0);
      else begin
        m_a = aq.pop_front();
        check("aw_is_write", 32'(m_a.wr), 32'd1);
        check("awid",   32'(axi.awid),   32'(m_a.id));
        check("awaddr", axi.awaddr,      m_a.addr);
        check("awsize", 32'(axi.awsize), 32'(m_a.size));
        check("awlen_burst", {22'd0, axi.awlen, axi.awburst}, 32'h1);
        check("aw_lock_cache_prot", 32'({axi.awlock, axi.awcache, axi.awprot}), 32'd0);
      end
    end
    if (w_hs) begin
      if (wq.size() == 0) check("w_unexpected", 32'(axi.wvalid), 32'd0);
      else begin
        m_w = wq.pop_front();
        check("wid",   32'(axi.wid),   32'(m_w.id));
        check("wdata", axi.wdata,      m_w.data);
        check("wstrb", 32'(axi.wstrb), 32'(m_w.strb));
        check("wlast", 32'(axi.wlast), 32'd1);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      ok_cyc = cyc;
      if (cq.size() == 0) check("data_ok_unexpected", 32'({inst_data_ok, data_data_ok}), 32'd0);
      else begin
        m_c = cq.pop_front();
        check("data_ok_port", 32'(data_data_ok), 32'(m_c.port));
        check("inst_ok_port", 32'(inst_data_ok), 32'(!m_c.port));
        if (!m_c.wr) check("rdata", m_c.port ? data_rdata : inst_rdata, m_c.rdata);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  int acc_cyc = 0;

  task automatic push_exp(input bit port, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rval);
    aexp_t a;
    wexp_t w;
    cexp_t c;
    a.wr = wr; a.id = port ? 4'd1 : 4'd0; a.addr = addr; a.size = exp_size(size);
    aq.push_back(a);
    if (wr) begin
      w.id = a.id; w.data = wdata; w.strb = exp_strb(size, addr);
      wq.push_back(w);
    end else begin
      rq.push_back(rval);
    end
    c.port = port; c.wr = wr; c.rdata = rval;
    cq.push_back(c);
  endtask

  task automatic wait_done();
    int n = 0;
    while (cq.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("done_timeout", 32'(cq.size()), 32'd0);
  endtask

  task automatic issue(input bit port, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rval, output int waited);
    bit ok = 0;
    @(posedge clk); #1;
    if (port) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
    end
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      ok = port ? data_addr_ok : inst_addr_ok;
      if (ok) break;
      waited++;
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    acc_cyc = cyc;
    if (ok) push_exp(port, wr, size, addr, wdata, rval);
    @(posedge clk); #1;
    inst_req = 1'b0;
    data_req = 1'b0;
    wait_done();
  endtask

  // ---------------- Main sequence ----------------
  int  waited;
  int  acc2;
  bit  got;

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 32'({axi.arvalid, axi.awvalid, axi.wvalid}), 32'd0);
    check("rst_readys", 32'({axi.rready, axi.bready}), 32'd0);
    check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    resetn = 1'b1;

    // Inst word read, zero-wait AXI: arvalid at +1, data_ok at +3
    issue(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C1D_BFC0, waited);
    check("ird_accept_wait", 32'(waited), 32'd0);
    check("ird_arvalid_lat", 32'(ar_first_cyc - acc_cyc), 32'd1);
    check("ird_data_ok_lat", 32'(ok_cyc - acc_cyc), 32'd3);
    check("ird_rdata", inst_rdata, 32'h3C1D_BFC0);

    // Data byte write at offset 3: data_ok one cycle after the B handshake
    issue(1'b1, 1'b1, 2'd0, 32'h1FAF_0003, 32'h0000_00AB, 32'h0, waited);
    check("bwr_ok_after_b", 32'(ok_cyc - b_hs_cyc), 32'd1);
    check("inst_rdata_hold", inst_rdata, 32'h3C1D_BFC0);

    // Simultaneous requests: data first, inst only at the IDLE after data_ok
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0004;
    #1;
    check("both_data_accept", 32'(data_addr_ok), 32'd1);
    check("both_inst_blocked", 32'(inst_addr_ok), 32'd0);
    push_exp(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'h1111_2222);
    @(posedge clk); #1;
    data_req = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (inst_addr_ok) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("both_inst_accept", 32'(got), 32'd1);
    acc2 = cyc;
    check("both_inst_after_ok", 32'(acc2 - ok_cyc), 32'd1);
    if (got) push_exp(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 32'h2468_ACE0);
    @(posedge clk); #1;
    inst_req = 1'b0;
    wait_done();
    check("data_rdata_hold", data_rdata, 32'h1111_2222);
    check("inst_rdata_new", inst_rdata, 32'h2468_ACE0);

    // AW delayed 3 cycles, W immediate
    aw_delay = 3; aw_hi_cnt = 0; w_hi_cnt = 0;
    issue(1'b1, 1'b1, 2'd2, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, waited);
    check("awdly_awvalid_cycles", 32'(aw_hi_cnt), 32'd4);
    check("awdly_wvalid_cycles", 32'(w_hi_cnt), 32'd1);
    check("awdly_bready_after_aw", 32'(br_first_cyc - aw_hs_cyc), 32'd1);
    aw_delay = 0;

    // W delayed 2 cycles, AW immediate
    w_delay = 2; aw_hi_cnt = 0; w_hi_cnt = 0;
    issue(1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h1234_5678, 32'h0, waited);
    check("wdly_awvalid_cycles", 32'(aw_hi_cnt), 32'd1);
    check("wdly_wvalid_cycles", 32'(w_hi_cnt), 32'd3);
    check("wdly_bready_after_w", 32'(br_first_cyc - w_hs_cyc), 32'd1);
    w_delay = 0;

    // Half write at offset 2, and a size-3 read mapped to word
    issue(1'b1, 1'b1, 2'd1, 32'h8000_0012, 32'hBEEF_0000, 32'h0, waited);
    issue(1'b1, 1'b0, 2'd3, 32'h8000_0010, 32'h0, 32'h5555_AAAA, waited);

    // Random traffic with random slave delays
    for (int t = 0; t < 12; t++) begin
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, waited);
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;

    // Reset while in RD_DATA abandons the read
    r_delay = 6;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h2000_0000;
    #1;
    check("rst_rd_accept", 32'(data_addr_ok), 32'd1);
    push_exp(1'b1, 1'b0, 2'd2, 32'h2000_0000, 32'h0, 32'h7777_7777);
    @(posedge clk); #1;
    data_req = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (axi.rready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("rst_saw_rready", 32'(got), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_rready", 32'(axi.rready), 32'd0);
    check("rst_mid_arvalid", 32'(axi.arvalid), 32'd0);
    check("rst_mid_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst_mid_data_rdata", data_rdata, 32'h0);
    cq.delete(); aq.delete(); wq.delete(); rq.delete();
    r_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    issue(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0, 32'h0BAD_F00D, waited);
    check("post_rst_accept_wait", 32'(waited), 32'd0);
    check("post_rst_rdata", inst_rdata, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
